// File: rtl/sparse_pkg.sv
// rtl/sparse_pkg.sv - shared instruction codes, lane selects and feeder FSM states
package sparse_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // index bit meaning, and which lane index_w[0] selects as the weight
  localparam logic LANE0_SEL  = 1'b0;
  localparam logic LANE1_SEL  = 1'b1;
  localparam logic INDEX_USED = 1'b0;
  localparam logic INDEX_SKIP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DRAIN = 2'b11
  } feed_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered read data; pop and push may coincide at full
module sync_fifo #(
  parameter int width = 10,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [aw:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (aw+1)'(depth));
  assign do_pop  = rd_en & ~empty;
  // a pop in the same cycle frees the slot, so a push at full is still taken
  assign do_push = wr_en & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + aw'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (aw+1)'(1);
        2'b01:   count <= count - (aw+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sparse_west_feeder.sv
// rtl/sparse_west_feeder.sv - west-edge feeder for one mac_tile row: FIFO, LOAD/EXEC/DRAIN sequencing
// Optional SWF_STALL_CNT_EN adds a saturating bubble counter output stall_cnt.
module sparse_west_feeder
  import sparse_pkg::*;
#(
  parameter int bw              = 4,
  parameter int index_selection = 2,
  parameter int col             = 8,
  parameter int fifo_depth      = 16,
  parameter int len_bw          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [bw*index_selection-1:0] wr_data,
  input  logic [1:0]                    wr_index,
  output logic                          full,
  input  logic                          start,
  input  logic [len_bw-1:0]             exec_len,
  output logic [bw*index_selection-1:0] out_w,
  output logic [1:0]                    inst_w,
  output logic [1:0]                    index_w,
`ifdef SWF_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          busy,
  output logic                          done
);

  localparam int dw     = bw * index_selection;
  localparam int fw     = dw + 2;
  localparam int cnt_bw = max_int(len_bw, $clog2(col + 1));

  feed_state_t       state;
  feed_state_t       state_nxt;
  logic [cnt_bw-1:0] beat_cnt;
  logic [len_bw-1:0] exec_len_q;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              pop;
  logic              fifo_empty;
  logic [fw-1:0]     fifo_rd;
  logic              last_col;
  logic              last_exec;
  logic [1:0]        inst_q;
  logic              busy_q;
  logic              done_q;

  // the FIFO read register doubles as the out_w/index_w output register
  sync_fifo #(
    .width (fw),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({wr_index, wr_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign pop       = ((state == ST_LOAD) || (state == ST_EXEC)) && !fifo_empty;
  assign last_col  = (beat_cnt == cnt_bw'(col - 1));
  assign last_exec = (beat_cnt == (cnt_bw'(exec_len_q) - cnt_bw'(1)));

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (pop) begin
          if (last_col) begin
            cnt_clr   = 1'b1;
            state_nxt = (exec_len_q == '0) ? ST_DRAIN : ST_EXEC;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (pop) begin
          if (last_exec) begin
            cnt_clr   = 1'b1;
            state_nxt = ST_DRAIN;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (last_col) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      exec_len_q <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) begin
        beat_cnt <= '0;
      end else if (cnt_inc) begin
        beat_cnt <= beat_cnt + cnt_bw'(1);
      end
      if ((state == ST_IDLE) && start) begin
        exec_len_q <= exec_len;
      end
    end
  end

  // control outputs are registered so they line up with the FIFO read data
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= INST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (pop) begin
        inst_q <= (state == ST_LOAD) ? INST_LOAD : INST_EXEC;
      end else begin
        inst_q <= INST_IDLE;
      end
      busy_q <= (state != ST_IDLE);
      done_q <= (state == ST_DRAIN) && last_col;
    end
  end

`ifdef SWF_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (((state == ST_LOAD) || (state == ST_EXEC)) && fifo_empty
                 && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign out_w   = fifo_rd[dw-1:0];
  assign index_w = fifo_rd[dw+1:dw];
  assign inst_w  = inst_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/sparse_west_feeder.md
Name: sparse_west_feeder

Overview:
- Drives the west edge of one mac_tile row: sources in_w, inst_w and index_w for a chain of col tiles.
- Buffers packed two-lane words plus 2-bit lane-index vectors from the L0/SRAM side in an internal FIFO.
- Sequences a kernel-load phase (inst 2'b01, col beats) and then an execute phase (inst 2'b10, exec_len beats).
- Emits done when the row has finished its stream.

Parameters:
- bw, 4, width of one lane value
- index_selection, 2, lanes per packed word (fixed at 2 by the index encoding)
- col, 8, tiles in the row = load beats per kernel load
- fifo_depth, 16, entries in the input FIFO (power of two)
- len_bw, 8, width of the execute-length counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- wr_en  input  1  push {wr_index, wr_data} into the FIFO
- wr_data  input  bw*index_selection  packed lanes; lane0 = [bw-1:0], lane1 = [2*bw-1:bw]
- wr_index  input  2  per-lane index bits; 0 = lane used, 1 = lane skipped
- full  output  1  FIFO full
- start  input  1  one-cycle pulse; begins LOAD when IDLE
- exec_len  input  len_bw  execute beats; sampled on start
- out_w  output  bw*index_selection  to tile in_w
- inst_w  output  2  to tile inst_w; [1] = execute, [0] = kernel load
- index_w  output  2  to tile index_w
- busy  output  1  high from LOAD through DRAIN
- done  output  1  one-cycle pulse on the final cycle of DRAIN

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: out_w = 0, inst_w = 2'b00, index_w = 2'b00, busy = 0, done = 0, full = 0. FIFO pointers and counters cleared. State = IDLE.
- Reset mid-operation: state returns to IDLE and FIFO contents are discarded.
- FSM states: IDLE, LOAD, EXEC, DRAIN.
- IDLE:
  - start = 1 → LOAD; beat counter cleared; exec_len latched.
  - start = 1 with exec_len = 0 → LOAD; after LOAD goes straight to DRAIN.
  - start while not IDLE is ignored.
- LOAD: each cycle the FIFO is non-empty, pop one entry and register it.
  - Outputs next cycle: out_w = data, index_w = index, inst_w = 2'b01.
  - Beat k loads tile k. index_w[0] picks the weight lane (0 → lane0, 1 → lane1).
  - After col popped beats → EXEC.
- EXEC: same pop rule, with inst_w = 2'b10.
  - index_w carries both lane bits; a tile's activation update happens only when its selected bit = 0.
  - After exec_len popped beats → DRAIN.
- Bubbles (FIFO empty in LOAD or EXEC): drive inst_w = 2'b00; out_w and index_w hold their last values; the beat counter does not advance.
- DRAIN: inst_w = 2'b00 for exactly col cycles so the last beat crosses the row. done pulses on the last DRAIN cycle, then → IDLE.
- Latency: start to first non-zero inst_w = 2 cycles if the FIFO is non-empty (state register, then output register).
- FIFO:
  - Push when wr_en & !full; a push while full is dropped.
  - Simultaneous push and pop when full is allowed; the count is unchanged.
  - full is combinational from the count.
  - Pointers wrap modulo fifo_depth.
- Width rules: beat counter is max(len_bw, clog2(col+1)) bits. exec_len is unsigned with no wrap; maximum is 2^len_bw − 1.

Optional Feature:
- Macro: SWF_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], counting bubble cycles in LOAD and EXEC.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on start.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (sparse_pkg):
  - localparams INST_IDLE = 2'b00, INST_LOAD = 2'b01, INST_EXEC = 2'b10.
  - FSM state encodings.
  - Lane-select constants.
- One sub-module: sync_fifo, synchronous, parameterised by width and depth, 1-cycle read-registered.
  - Instantiated with width bw*index_selection + 2.

Test Plan:
1. Reset with FIFO non-empty and state in EXEC → next cycle inst_w = 00, out_w = 0, busy = 0, full = 0; a later start with an empty FIFO emits no beat.
2. col = 8: push 8 load words (data 8'hk1, index 2'b00) then 4 exec words; start with exec_len = 4 → 8 cycles of inst_w = 01 with data in order, 4 of inst_w = 10, 8 DRAIN cycles, then done asserted for exactly 1 cycle.
3. Bubble: FIFO empty for 3 cycles mid-EXEC → inst_w = 00 for 3 cycles, out_w held, total exec beats still 4, done delayed by 3 cycles.
4. exec_len = 0 → LOAD beats then directly DRAIN; no inst_w = 10 observed; done asserted.
5. FIFO boundaries: fill to fifo_depth → full = 1; push while full is dropped; simultaneous push and pop at full keeps full = 1; pointer wrap preserves order across 40 pushes.
6. With SWF_STALL_CNT_EN defined and scenario 3 → stall_cnt = 3; a new start clears it to 0.
